// File: rtl/pipeline_control_sequencer.sv
// Stall/flush sequencer for the 5-stage pipeline. It arbitrates memory waits, divider
// occupancy, hazard stalls and taken branches, and keeps the stall and flush statistics.
module pipeline_control_sequencer #(
  parameter int DIV_CYCLES  = 32,
  parameter int MEM_TIMEOUT = 255,
  parameter int CNT_WIDTH   = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 hazard_stall,
  input  logic                 branch_taken,
  input  logic                 ex_is_div,
  input  logic                 mem_req,
  input  logic                 mem_ready,
  input  logic                 imem_ready,
  output logic                 pc_write,
  output logic                 pc_sel_branch,
  output logic                 if_id_write,
  output logic                 if_id_flush,
  output logic                 id_ex_write,
  output logic                 id_ex_flush,
  output logic                 ex_mem_write,
  output logic                 ex_mem_flush,
  output logic                 mem_wb_write,
  output logic                 mem_wb_flush,
  output logic                 div_start,
  output logic                 mem_error,
  output logic [CNT_WIDTH-1:0] stall_count,
  output logic [CNT_WIDTH-1:0] flush_count
);

  localparam int DIV_W  = $clog2(DIV_CYCLES) + 1;
  localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);
  localparam logic [DIV_W-1:0]  DIV_LOAD = DIV_W'(DIV_CYCLES - 1);
  localparam logic [DIV_W-1:0]  DIV_EXIT = DIV_W'(2);
  localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MEM_TIMEOUT);

  typedef enum logic [1:0] {RUN, DIV_BUSY, DIV_DONE} state_t;

  state_t            state, state_next;
  logic [DIV_W-1:0]  div_cnt, div_cnt_next;
  logic [WAIT_W-1:0] wait_cnt;
  logic              mem_stall, launch, div_hold, branch_fire;

  assign mem_stall = mem_req & ~mem_ready;
  assign launch    = (state == RUN) & ex_is_div & ~mem_stall;
  assign div_hold  = launch | (state == DIV_BUSY);

  // The busy phase ends once the decremented count reaches 1, so the front end is held
  // for DIV_CYCLES-1 cycles including the launch cycle.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    state_next   = state;
    div_cnt_next = div_cnt;
    unique case (state)
      RUN: begin
        if (launch) begin
          state_next   = DIV_BUSY;
          div_cnt_next = DIV_LOAD;
        end
      end
      DIV_BUSY: begin
        div_cnt_next = div_cnt - 1'b1;
        if (div_cnt <= DIV_EXIT) state_next = DIV_DONE;
      end
      DIV_DONE: if (!mem_stall) state_next = RUN;
      default:  state_next = RUN;
    endcase
  end

  always_comb begin
    pc_write      = 1'b1;
    pc_sel_branch = 1'b0;
    if_id_write   = 1'b1;
    if_id_flush   = 1'b0;
    id_ex_write   = 1'b1;
    id_ex_flush   = 1'b0;
    ex_mem_write  = 1'b1;
    ex_mem_flush  = 1'b0;
    mem_wb_write  = 1'b1;
    mem_wb_flush  = 1'b0;
    div_start     = 1'b0;
    branch_fire   = 1'b0;
    if (reset) begin
      {pc_write, if_id_write, id_ex_write, ex_mem_write, mem_wb_write} = '0;
      {if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush}          = '1;
    end else begin
      div_start = launch;
      if (mem_stall) begin
        {pc_write, if_id_write, id_ex_write, ex_mem_write} = '0;
        mem_wb_flush = 1'b1;
      end else if (div_hold) begin
        {pc_write, if_id_write, id_ex_write} = '0;
        ex_mem_flush = 1'b1;
      end else if (hazard_stall) begin
        pc_write    = 1'b0;
        if_id_write = 1'b0;
        id_ex_flush = 1'b1;
      end else if (branch_taken) begin
        pc_sel_branch = 1'b1;
        if_id_flush   = 1'b1;
        branch_fire   = 1'b1;
      end else if (!imem_ready) begin
        pc_write    = 1'b0;
        if_id_flush = 1'b1;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= RUN;
      div_cnt     <= '0;
      wait_cnt    <= '0;
      mem_error   <= 1'b0;
      stall_count <= '0;
      flush_count <= '0;
    end else begin
      state   <= state_next;
      div_cnt <= div_cnt_next;
      if (!mem_stall)               wait_cnt <= '0;
      else if (wait_cnt != WAIT_MAX) wait_cnt <= wait_cnt + 1'b1;
      if (mem_stall && wait_cnt == WAIT_MAX) mem_error <= 1'b1;
      if (!pc_write)   stall_count <= stall_count + 1'b1;
      if (branch_fire) flush_count <= flush_count + 1'b1;
    end
  end

endmodule
